key_gesture_decoder: RTL and testbench

- Consumes the debounced one-cycle press/release pulses produced by the key debouncer and classifies them into user gestures.
- Gestures: short click, double click, long press (with held level).
- Sits between the debouncer and application/LED logic. Same clock domain as the debouncer; all inputs are already synchronous.

---
 rtl/key_gesture_decoder.sv | 120 ++++++++++++
 tb/tb_key_gesture_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_gesture_decoder.sv
// Classifies debounced press/release pulses into short click, double click and
// long press gestures. All outputs are registered; pulses last one cycle.
module key_gesture_decoder #(
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 25000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_press,
  input  logic i_release,
  output logic o_short,
  output logic o_double,
  output logic o_long,
  output logic o_held,
  output logic o_busy
);

  typedef enum logic [4:0] {
    IDLE           = 5'b00001,
    PRESSED        = 5'b00010,
    LONG_HELD      = 5'b00100,
    WAIT_SECOND    = 5'b01000,
    SECOND_PRESSED = 5'b10000
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
  logic             busy_q, busy_d;
  logic             press_v, release_v;

  // A simultaneous press and release is treated as no event at all.
  assign press_v   = i_press & ~i_release;
  assign release_v = i_release & ~i_press;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_v) state_d = PRESSED;
      end
      PRESSED: begin
        if (release_v) begin
          state_d = WAIT_SECOND;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (release_v) state_d = IDLE;
      end
      WAIT_SECOND: begin
        if (press_v) begin
          state_d = SECOND_PRESSED;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (release_v) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == PRESSED || state_q == WAIT_SECOND) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    held_d = (state_d == LONG_HELD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      held_q   <= held_d;
      busy_q   <= busy_d;
    end
  end

  assign o_short  = short_q;
  assign o_double = double_q;
  assign o_long   = long_q;
  assign o_held   = held_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_key_gesture_decoder.sv
// Self-checking bench for key_gesture_decoder: scenario table, hand-written
// reset/back-to-back sequences, and random traffic against an event-level model.
module tb_key_gesture_decoder;

  localparam int LONG = 20;
  localparam int GAP  = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic press, release_k;
  logic o_short, o_double, o_long, o_held, o_busy;

  int checks = 0;
  int errors = 0;

  key_gesture_decoder #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP),
    .CNT_W      (5)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_press  (press),
    .i_release(release_k),
    .o_short  (o_short),
    .o_double (o_double),
    .o_long   (o_long),
    .o_held   (o_held),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  // Event-level model: tracks how many presses the gesture has seen, whether
  // the key is down, and the cycle of the last accepted event.
  int   m_cyc;
  bit   m_active, m_down, m_long_on;
  int   m_presses, m_ev;
  bit   e_short, e_double, e_long;

  function automatic void model_reset();
    m_active = 0; m_down = 0; m_long_on = 0; m_presses = 0; m_ev = 0;
    e_short = 0; e_double = 0; e_long = 0;
  endfunction

  function automatic void model_edge(input logic p_in, input logic r_in);
    bit p, r;
    p = p_in && !r_in;
    r = r_in && !p_in;
    e_short = 0; e_double = 0; e_long = 0;
    if (!m_active) begin
      if (p) begin
        m_active = 1; m_presses = 1; m_down = 1; m_long_on = 0; m_ev = m_cyc;
      end
    end else if (m_long_on) begin
      if (r) begin m_active = 0; m_long_on = 0; m_down = 0; end
    end else if (m_presses == 1 && m_down) begin
      if (r) begin
        m_down = 0; m_ev = m_cyc;
      end else if (m_cyc - m_ev == LONG) begin
        m_long_on = 1; e_long = 1;
      end
    end else if (m_presses == 1) begin
      if (p) begin
        m_presses = 2; m_down = 1; m_ev = m_cyc;
      end else if (m_cyc - m_ev == GAP) begin
        m_active = 0; e_short = 1;
      end
    end else begin
      if (r) begin m_active = 0; m_down = 0; e_double = 1; end
    end
    m_cyc++;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ":short"},  o_short,  e_short);
    check({tag, ":double"}, o_double, e_double);
    check({tag, ":long"},   o_long,   e_long);
    check({tag, ":held"},   o_held,   m_long_on);
    check({tag, ":busy"},   o_busy,   m_active);
  endtask

  // Drive one edge's inputs, let the edge happen, then sample 1 time unit later.
  task automatic step(input logic p, input logic r, input string tag);
    press = p;
    release_k = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
    compare_model(tag);
    press = 1'b0;
    release_k = 1'b0;
  endtask

  // Scenario table: event edges (-1 = none) and the edges after which each
  // output is expected high. Level windows are [from, to).
  typedef struct {
    string name;
    int pa, ra, pb, rb, xp, both_at, n;
    int short_at, double_at, long_at;
    int held_from, held_to, busy_from, busy_to;
  } scen_t;

  scen_t scen [8];

  initial begin
    scen[0] = '{"short",       0,  5, -1, -1, -1, -1, 20, 15, -1, -1,  0,  0, 0, 15};
    scen[1] = '{"long",        0, 30, -1, -1, -1, -1, 35, -1, -1, 20, 20, 30, 0, 30};
    scen[2] = '{"double",      0,  4,  9, 40, -1, -1, 45, -1, 40, -1,  0,  0, 0, 40};
    scen[3] = '{"rel_at_long", 0, 20, -1, -1, -1, -1, 35, 30, -1, -1,  0,  0, 0, 30};
    scen[4] = '{"press_at_gap",0,  3, 13, 16, -1, -1, 20, -1, 16, -1,  0,  0, 0, 16};
    scen[5] = '{"both_idle",  -1, -1, -1, -1, -1,  0,  5, -1, -1, -1,  0,  0, 0,  0};
    scen[6] = '{"stray_rel",  -1,  0, -1, -1, -1, -1,  5, -1, -1, -1,  0,  0, 0,  0};
    scen[7] = '{"extra_press", 0,  5, -1, -1,  2, -1, 20, 15, -1, -1,  0,  0, 0, 15};

    press = 1'b0;
    release_k = 1'b0;
    rst_n = 1'b0;
    m_cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset:short", o_short, 1'b0);
    check("reset:busy",  o_busy,  1'b0);
    check("reset:held",  o_held,  1'b0);
    rst_n = 1'b1;

    for (int s = 0; s < 8; s++) begin
      for (int e = 0; e < scen[s].n; e++) begin
        logic p, r;
        p = (e == scen[s].pa || e == scen[s].pb || e == scen[s].xp || e == scen[s].both_at);
        r = (e == scen[s].ra || e == scen[s].rb || e == scen[s].both_at);
        step(p, r, scen[s].name);
        check({scen[s].name, ":tbl_short"},  o_short,  e == scen[s].short_at);
        check({scen[s].name, ":tbl_double"}, o_double, e == scen[s].double_at);
        check({scen[s].name, ":tbl_long"},   o_long,   e == scen[s].long_at);
        check({scen[s].name, ":tbl_held"},   o_held,
              e >= scen[s].held_from && e < scen[s].held_to);
        check({scen[s].name, ":tbl_busy"},   o_busy,
              e >= scen[s].busy_from && e < scen[s].busy_to);
      end
      repeat (3) step(1'b0, 1'b0, "gap");
    end

    // Reset mid-gesture: press@0, release@5, reset asserted before edge 8.
    step(1'b1, 1'b0, "rst_seq");
    for (int e = 1; e < 8; e++) step(1'b0, e == 5, "rst_seq");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid:busy",  o_busy,  1'b0);
    check("rst_mid:short", o_short, 1'b0);
    check("rst_mid:held",  o_held,  1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 15; e++) begin
      step(1'b0, 1'b0, "post_rst_idle");
      check("post_rst:no_short", o_short, 1'b0);
    end

    // Fresh click followed by a back-to-back press on the first IDLE cycle.
    for (int e = 0; e <= 15; e++) step(e == 0, e == 5, "fresh_click");
    check("fresh_click:short", o_short, 1'b1);
    check("fresh_click:idle",  o_busy,  1'b0);
    step(1'b1, 1'b0, "b2b");
    check("b2b:busy", o_busy, 1'b1);
    step(1'b0, 1'b1, "b2b");
    repeat (GAP + 2) step(1'b0, 1'b0, "b2b");

    // Random traffic with sparse events so all gesture types complete.
    for (int i = 0; i < 4000; i++) begin
      logic p, r;
      p = ($urandom_range(0, 13) == 0);
      r = ($urandom_range(0, 11) == 0);
      step(p, r, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
